uart_rx_deser_gen: RTL and testbench
====================================

Name: uart_rx_deser_gen

Overview:
Parametrised successor to the UART RX deserializer. It accepts one sampled data bit per deser_en strobe from the RX FSM and counts bits internally, so no external bit counter is needed. It supports configurable data width and bit order. It assembles each frame in a private shift register and publishes a completed word, with its XOR parity, in one atomic update. It also flags excess data strobes as overflow.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; legal range 5..9
MSB_FIRST, 0, 0 = first received bit lands in P_DATA[0] (UART standard); 1 = first received bit lands in P_DATA[DATA_WIDTH-1]

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
start_clr  input  1  one-cycle pulse from the RX FSM at start-bit acceptance; begins a new frame
deser_en  input  1  one-cycle strobe; sampled_bit is a valid data bit this cycle
sampled_bit  input  1  majority-voted bit from the sampler
P_DATA  output  DATA_WIDTH  last completed word; updates only at frame completion
data_par  output  1  XOR of all DATA_WIDTH bits of P_DATA; updates with P_DATA
byte_done  output  1  one-cycle pulse; P_DATA and data_par were updated this cycle
bit_idx  output  CNT_W  number of data bits captured in the current frame (0..DATA_WIDTH)
overflow  output  1  sticky; set when deser_en arrives after the frame is full

Behaviour:
- CNT_W = $clog2(DATA_WIDTH+1), a localparam.
- Reset (RST=1, async): state=IDLE; shift register, bit_idx, parity accumulator, P_DATA, data_par, byte_done and overflow all 0.
- States are IDLE, SHIFT and FULL.
- IDLE:
  - deser_en is ignored; overflow is not set.
  - start_clr moves the block to SHIFT and clears bit_idx, shift register and accumulator.
- SHIFT, on deser_en without start_clr:
  - The bit is stored.
    - MSB_FIRST=0: shift right, new bit enters at bit DATA_WIDTH-1.
    - MSB_FIRST=1: shift left, new bit enters at bit 0.
  - Accumulator ^= sampled_bit.
  - bit_idx increments by 1.
- Completion: on the deser_en that makes bit_idx reach DATA_WIDTH, at that same edge:
  - P_DATA <= completed word (including the current bit).
  - data_par <= accumulator ^ sampled_bit.
  - byte_done <= 1 for exactly one cycle.
  - State moves to FULL.
  - Latency is one clock from the final strobe to visible data.
- FULL:
  - deser_en sets overflow=1.
  - P_DATA, data_par and bit_idx stay unchanged.
  - start_clr moves the block to SHIFT, clears bit_idx, shift register and accumulator, and clears overflow.
- start_clr in SHIFT (frame abandoned mid-word):
  - Restarts the frame with bit_idx=0.
  - P_DATA and data_par keep the previous completed word.
  - No byte_done.
- start_clr together with deser_en in the same cycle: start_clr wins and the bit is discarded (bit_idx=0 afterwards).
- P_DATA never shows a partial word. It holds the last completed word through subsequent frames until the next completion.
- Back-to-back frames: completion and a start_clr in the very next cycle are legal. byte_done is unaffected.
- Reset mid-frame: all state returns to reset values immediately; no byte_done is emitted.

Decomposition:
- Shared package uart_rx_pkg holds:
  - the state enum (IDLE=2'd0, SHIFT=2'd1, FULL=2'd2);
  - constants UART_DW_MIN=5 and UART_DW_MAX=9;
  - an elaboration check that DATA_WIDTH is within range.
- No sub-module. The shift register, counter and accumulator are one tightly coupled datapath under a single FSM.

Test Plan:
- DATA_WIDTH=8, MSB_FIRST=0: start_clr, then bits 1,0,1,0,0,1,0,1 -> P_DATA=8'hA5, data_par=0, byte_done high for exactly 1 cycle, bit_idx=8, overflow=0.
- DATA_WIDTH=8, MSB_FIRST=1: same bit stream -> P_DATA=8'hA5 (the stream is a palindrome); then stream 1,0,0,0,0,0,0,0 -> P_DATA=8'h80, data_par=1.
- DATA_WIDTH=7, LSB-first, word 7'h13 (bits 1,1,0,0,1,0,0) -> P_DATA=7'h13, data_par=1; also check P_DATA stays at the prior value during bits 1..6.
- Overflow: after 8'hA5 completes, one more deser_en -> overflow=1 and P_DATA=8'hA5 unchanged; then start_clr -> overflow=0, bit_idx=0.
- Abort: start_clr, 4 bits, then start_clr asserted together with deser_en -> bit_idx=0, no byte_done, P_DATA keeps the previous word; a full frame of 8'h3C then completes correctly.
- Reset: assert RST asynchronously (mid-cycle) after 5 of 8 bits -> all outputs 0 immediately; after release, start_clr plus 8'hFF -> P_DATA=8'hFF, data_par=0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and limits for the UART RX deserializer
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int UART_DW_MIN = 5;
  localparam int UART_DW_MAX = 9;

  function automatic bit dw_in_range(input int dw);
    return (dw >= UART_DW_MIN) && (dw <= UART_DW_MAX);
  endfunction

endpackage

// File: rtl/uart_rx_deser_gen.sv
// rtl/uart_rx_deser_gen.sv - parametrised UART RX deserializer with internal bit count
module uart_rx_deser_gen
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0,
  localparam int CNT_W     = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_clr,
  input  logic                  deser_en,
  input  logic                  sampled_bit,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_par,
  output logic                  byte_done,
  output logic [CNT_W-1:0]      bit_idx,
  output logic                  overflow
);

  if (!dw_in_range(DATA_WIDTH)) begin : g_dw_check
    $error("uart_rx_deser_gen: DATA_WIDTH %0d outside %0d..%0d",
           DATA_WIDTH, UART_DW_MIN, UART_DW_MAX);
  end

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  acc_q, acc_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  par_q, par_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] shift_in;
  logic                  last_bit;

  // Word under assembly including the bit arriving this cycle.
  always_comb begin
    shift_in = shift_q;
    if (MSB_FIRST) begin
      shift_in = {shift_q[DATA_WIDTH-2:0], sampled_bit};
    end else begin
      shift_in = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
    end
  end

  assign last_bit = (cnt_q == CNT_W'(DATA_WIDTH - 1));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pdata_d = pdata_q;
    par_d   = par_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start_clr) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
          acc_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (start_clr) begin
          shift_d = '0;
          cnt_d   = '0;
          acc_d   = 1'b0;
        end else if (deser_en) begin
          shift_d = shift_in;
          acc_d   = acc_q ^ sampled_bit;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_bit) begin
            // Publish the full word and parity in one atomic update.
            pdata_d = shift_in;
            par_d   = acc_q ^ sampled_bit;
            done_d  = 1'b1;
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (start_clr) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
          acc_d   = 1'b0;
          ovf_d   = 1'b0;
        end else if (deser_en) begin
          ovf_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      pdata_q <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      pdata_q <= pdata_d;
      par_q   <= par_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign P_DATA    = pdata_q;
  assign data_par  = par_q;
  assign byte_done = done_q;
  assign bit_idx   = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_rx_deser_gen.sv
// tb/tb_uart_rx_deser_gen.sv - self-checking bench for uart_rx_deser_gen (three configurations)
module tb_uart_rx_deser_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] sc = '0;
  logic [2:0] en = '0;
  logic [2:0] sb = '0;

  logic [7:0] pd0, pd1;
  logic [6:0] pd2;
  logic [3:0] bi0, bi1;
  logic [2:0] bi2;
  logic       par0, par1, par2, done0, done1, done2, ovf0, ovf1, ovf2;

  logic [8:0] pd_v [3];
  logic [3:0] bi_v [3];
  logic [2:0] par_v, done_v, ovf_v;

  assign pd_v[0] = {1'b0, pd0};
  assign pd_v[1] = {1'b0, pd1};
  assign pd_v[2] = {2'b0, pd2};
  assign bi_v[0] = bi0;
  assign bi_v[1] = bi1;
  assign bi_v[2] = {1'b0, bi2};
  assign par_v   = {par2, par1, par0};
  assign done_v  = {done2, done1, done0};
  assign ovf_v   = {ovf2, ovf1, ovf0};

  always #5 CLK = ~CLK;

  uart_rx_deser_gen #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
    .CLK(CLK), .RST(RST), .start_clr(sc[0]), .deser_en(en[0]), .sampled_bit(sb[0]),
    .P_DATA(pd0), .data_par(par0), .byte_done(done0), .bit_idx(bi0), .overflow(ovf0));
  uart_rx_deser_gen #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
    .CLK(CLK), .RST(RST), .start_clr(sc[1]), .deser_en(en[1]), .sampled_bit(sb[1]),
    .P_DATA(pd1), .data_par(par1), .byte_done(done1), .bit_idx(bi1), .overflow(ovf1));
  uart_rx_deser_gen #(.DATA_WIDTH(7), .MSB_FIRST(1'b0)) u_lsb7 (
    .CLK(CLK), .RST(RST), .start_clr(sc[2]), .deser_en(en[2]), .sampled_bit(sb[2]),
    .P_DATA(pd2), .data_par(par2), .byte_done(done2), .bit_idx(bi2), .overflow(ovf2));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: frame phase (0 none, 1 collecting, 2 complete), bit list, published word.
  int         dw_of [3] = '{8, 8, 7};
  bit         msb_of [3] = '{1'b0, 1'b1, 1'b0};
  int         m_phase [3];
  int         m_n [3];
  bit         m_bits [3][9];
  logic [8:0] m_word [3];
  logic       m_par [3];
  logic       m_done [3];
  logic       m_ovf [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_phase[i] = 0; m_n[i] = 0; m_word[i] = '0;
      m_par[i] = 1'b0; m_done[i] = 1'b0; m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 1'b0;
      if (sc[i]) begin
        m_phase[i] = 1; m_n[i] = 0; m_ovf[i] = 1'b0;
      end else if (en[i]) begin
        if (m_phase[i] == 1) begin
          m_bits[i][m_n[i]] = sb[i];
          m_n[i]++;
          if (m_n[i] == dw_of[i]) begin
            logic [8:0] w;
            w = '0;
            for (int k = 0; k < dw_of[i]; k++) begin
              if (msb_of[i]) w[dw_of[i]-1-k] = m_bits[i][k];
              else           w[k] = m_bits[i][k];
            end
            m_word[i]  = w;
            m_par[i]   = logic'($countones(w) % 2);
            m_done[i]  = 1'b1;
            m_phase[i] = 2;
          end
        end else if (m_phase[i] == 2) begin
          m_ovf[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
    sc = '0; en = '0; sb = '0;
  endtask

  task automatic send_bit(input int inst, input logic b);
    en[inst] = 1'b1; sb[inst] = b;
    cycle();
  endtask

  task automatic send_start(input int inst);
    sc[inst] = 1'b1;
    cycle();
  endtask

  task automatic send_stream(input int inst, input logic [8:0] stream, input int n);
    for (int k = 0; k < n; k++) send_bit(inst, stream[k]);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    model_reset();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (pd_v[i] !== 9'h0 || par_v[i] !== 1'b0 || done_v[i] !== 1'b0 ||
          bi_v[i] !== 4'h0 || ovf_v[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state inst%0d got pd=%h par=%b done=%b idx=%0d ovf=%b want all 0",
                 i, pd_v[i], par_v[i], done_v[i], bi_v[i], ovf_v[i]);
      end
    end
    RST = 1'b0;
    // Strobes before any start_clr are ignored and never raise overflow.
    en = 3'b111; sb = 3'b111;
    cycle();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bi_v[i] !== 4'h0 || ovf_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_ignore inst%0d got idx=%0d ovf=%b done=%b want 0 0 0",
                 i, bi_v[i], ovf_v[i], done_v[i]);
      end
    end
  endtask

  task automatic test_lsb8();
    send_start(0);
    send_stream(0, 9'b0_1010_0101, 7);
    n_cmp++;
    if (pd_v[0] !== 9'h0 || done_v[0] !== 1'b0 || bi_v[0] !== 4'd7) begin
      n_bad++;
      $display("FAIL lsb8_partial got pd=%h done=%b idx=%0d want 0 0 7", pd_v[0], done_v[0], bi_v[0]);
    end
    send_bit(0, 1'b1);
    n_cmp++;
    if (pd_v[0] !== 9'h0A5 || par_v[0] !== 1'b0 || done_v[0] !== 1'b1 ||
        bi_v[0] !== 4'd8 || ovf_v[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL lsb8_word got pd=%h par=%b done=%b idx=%0d ovf=%b want a5 0 1 8 0",
               pd_v[0], par_v[0], done_v[0], bi_v[0], ovf_v[0]);
    end
    cycle();
    n_cmp++;
    if (done_v[0] !== 1'b0 || pd_v[0] !== 9'h0A5) begin
      n_bad++;
      $display("FAIL lsb8_done_width got done=%b pd=%h want 0 a5", done_v[0], pd_v[0]);
    end
  endtask

  task automatic test_msb8();
    send_start(1);
    send_stream(1, 9'b0_1010_0101, 8);
    n_cmp++;
    if (pd_v[1] !== 9'h0A5 || par_v[1] !== 1'b0 || done_v[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL msb8_palin got pd=%h par=%b done=%b want a5 0 1", pd_v[1], par_v[1], done_v[1]);
    end
    send_start(1);
    send_stream(1, 9'b0_0000_0001, 8);
    n_cmp++;
    if (pd_v[1] !== 9'h080 || par_v[1] !== 1'b1 || done_v[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL msb8_first_bit got pd=%h par=%b done=%b want 80 1 1", pd_v[1], par_v[1], done_v[1]);
    end
  endtask

  task automatic test_dw7();
    send_start(2);
    send_stream(2, 9'h055, 7);
    n_cmp++;
    if (pd_v[2] !== 9'h055 || par_v[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL dw7_first got pd=%h par=%b want 55 0", pd_v[2], par_v[2]);
    end
    send_start(2);
    for (int k = 0; k < 6; k++) begin
      logic [6:0] w;
      w = 7'h13;
      send_bit(2, w[k]);
      n_cmp++;
      if (pd_v[2] !== 9'h055 || done_v[2] !== 1'b0 || bi_v[2] !== 4'(k + 1)) begin
        n_bad++;
        $display("FAIL dw7_hold bit%0d got pd=%h done=%b idx=%0d want 55 0 %0d",
                 k, pd_v[2], done_v[2], bi_v[2], k + 1);
      end
    end
    send_bit(2, 1'b0);
    n_cmp++;
    if (pd_v[2] !== 9'h013 || par_v[2] !== 1'b1 || done_v[2] !== 1'b1 || bi_v[2] !== 4'd7) begin
      n_bad++;
      $display("FAIL dw7_word got pd=%h par=%b done=%b idx=%0d want 13 1 1 7",
               pd_v[2], par_v[2], done_v[2], bi_v[2]);
    end
  endtask

  task automatic test_overflow();
    send_bit(0, 1'b0);
    n_cmp++;
    if (ovf_v[0] !== 1'b1 || pd_v[0] !== 9'h0A5 || bi_v[0] !== 4'd8 || done_v[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_set got ovf=%b pd=%h idx=%0d done=%b want 1 a5 8 0",
               ovf_v[0], pd_v[0], bi_v[0], done_v[0]);
    end
    send_start(0);
    n_cmp++;
    if (ovf_v[0] !== 1'b0 || bi_v[0] !== 4'd0 || pd_v[0] !== 9'h0A5) begin
      n_bad++;
      $display("FAIL ovf_clear got ovf=%b idx=%0d pd=%h want 0 0 a5", ovf_v[0], bi_v[0], pd_v[0]);
    end
  endtask

  task automatic test_abort();
    send_stream(0, 9'h00F, 4);
    sc[0] = 1'b1; en[0] = 1'b1; sb[0] = 1'b1;
    cycle();
    n_cmp++;
    if (bi_v[0] !== 4'd0 || done_v[0] !== 1'b0 || pd_v[0] !== 9'h0A5) begin
      n_bad++;
      $display("FAIL abort got idx=%0d done=%b pd=%h want 0 0 a5", bi_v[0], done_v[0], pd_v[0]);
    end
    send_stream(0, 9'h03C, 8);
    n_cmp++;
    if (pd_v[0] !== 9'h03C || par_v[0] !== 1'b0 || done_v[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_next got pd=%h par=%b done=%b want 3c 0 1", pd_v[0], par_v[0], done_v[0]);
    end
  endtask

  task automatic test_reset_mid();
    send_start(0);
    send_stream(0, 9'h1FF, 5);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (pd_v[i] !== 9'h0 || par_v[i] !== 1'b0 || done_v[i] !== 1'b0 ||
          bi_v[i] !== 4'h0 || ovf_v[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL async_reset inst%0d got pd=%h par=%b done=%b idx=%0d ovf=%b want all 0",
                 i, pd_v[i], par_v[i], done_v[i], bi_v[i], ovf_v[i]);
      end
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    send_start(0);
    send_stream(0, 9'h1FF, 8);
    n_cmp++;
    if (pd_v[0] !== 9'h0FF || par_v[0] !== 1'b0 || done_v[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_recover got pd=%h par=%b done=%b want ff 0 1", pd_v[0], par_v[0], done_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] w;
    for (int f = 0; f < 4; f++) begin
      w = 9'($urandom_range(0, 255));
      send_start(1);
      send_stream(1, w, 8);
      n_cmp++;
      if (done_v[1] !== 1'b1 || pd_v[1] !== m_word[1] || par_v[1] !== m_par[1]) begin
        n_bad++;
        $display("FAIL b2b_word f%0d got done=%b pd=%h par=%b want 1 %h %b",
                 f, done_v[1], pd_v[1], par_v[1], m_word[1], m_par[1]);
      end
    end
    send_start(1);
    n_cmp++;
    if (done_v[1] !== 1'b0 || bi_v[1] !== 4'd0 || pd_v[1] !== m_word[1]) begin
      n_bad++;
      $display("FAIL b2b_restart got done=%b idx=%0d pd=%h want 0 0 %h",
               done_v[1], bi_v[1], pd_v[1], m_word[1]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        sc[i] = ($urandom_range(0, 11) == 0);
        en[i] = ($urandom_range(0, 2) != 0);
        sb[i] = 1'($urandom);
      end
      cycle();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (pd_v[i] !== m_word[i] || par_v[i] !== m_par[i] || done_v[i] !== m_done[i] ||
            bi_v[i] !== 4'(m_n[i]) || ovf_v[i] !== m_ovf[i]) begin
          n_bad++;
          $display("FAIL random c%0d inst%0d got pd=%h par=%b done=%b idx=%0d ovf=%b want %h %b %b %0d %b",
                   c, i, pd_v[i], par_v[i], done_v[i], bi_v[i], ovf_v[i],
                   m_word[i], m_par[i], m_done[i], m_n[i], m_ovf[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb8();
    test_msb8();
    test_dw7();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
